// File: rtl/link_pkg.sv
// Shared definitions for the sensor/actuator link stages: the receiver
// state encoding and the default word length / inter-bit timeout.
package link_pkg;

  localparam int DEFAULT_BIT_WIDTH      = 28;
  localparam int DEFAULT_TIMEOUT_CYCLES = 1000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } link_state_t;

endpackage

// File: rtl/serial_word_receiver_if.sv
// Word handshake between the serial receiver and the downstream reversal stage.
interface serial_word_receiver_if
  import link_pkg::*;
#(
  parameter int BIT_WIDTH = DEFAULT_BIT_WIDTH
);

  // valid/ready: a word transfers on every rising clk edge where word_valid
  // and word_ready are both high; once raised, word_valid and word_data stay
  // unchanged until that transfer (only reset may withdraw them), and
  // word_ready may be driven freely without waiting for word_valid.
  logic [BIT_WIDTH-1:0] word_data;
  logic                 word_valid;
  logic                 word_ready;

  modport master (
    output word_data,
    output word_valid,
    input  word_ready
  );

  modport slave (
    input  word_data,
    input  word_valid,
    output word_ready
  );

endinterface

// File: rtl/link_timeout_counter.sv
// Counts consecutive enabled cycles and flags the cycle in which the count
// reaches LIMIT, so the caller can act on the same clock edge.
module link_timeout_counter #(
  parameter int LIMIT = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int TO_W = $clog2(LIMIT + 1);

  logic [TO_W-1:0] count;

  // Saturates at LIMIT so a caller that ignores expiry never sees a wrap.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && (count != TO_W'(LIMIT))) begin
      count <= count + 1'b1;
    end
  end

  assign expired = enable && (count == TO_W'(LIMIT - 1));

endmodule

// File: rtl/serial_word_receiver.sv
// Assembles an LSB-first word from a strobed serial stream, offers it on a
// valid/ready handshake and reports timeout, restart and overrun faults.
module serial_word_receiver
  import link_pkg::*;
#(
  parameter int BIT_WIDTH      = DEFAULT_BIT_WIDTH,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ser_start,
  input  logic                  ser_valid,
  input  logic                  ser_bit,
  serial_word_receiver_if.master word,
  output logic                  busy,
  output logic                  frame_error,
  output logic                  overrun,
  output link_state_t           state_dbg
);

  localparam int CNT_W = $clog2(BIT_WIDTH + 1);
  localparam int IDX_W = $clog2(BIT_WIDTH);

  link_state_t          state;
  logic [BIT_WIDTH-1:0] word_q;
  logic [CNT_W-1:0]     bit_cnt;
  logic                 word_valid_q;

  logic [IDX_W-1:0]     bit_idx;
  logic                 last_bit;
  logic [BIT_WIDTH-1:0] start_word;
  logic [CNT_W-1:0]     start_cnt;
  logic                 to_clear;
  logic                 to_enable;
  logic                 timed_out;

  assign bit_idx  = bit_cnt[IDX_W-1:0];
  assign last_bit = (bit_cnt == CNT_W'(BIT_WIDTH - 1));

  // A frame start always wipes the register; a strobe in the same cycle
  // becomes bit 0 of the new frame.
  assign start_word = ser_valid ? {{(BIT_WIDTH-1){1'b0}}, ser_bit} : '0;
  assign start_cnt  = ser_valid ? CNT_W'(1) : '0;

  assign to_clear  = (state != SHIFT) || ser_valid || ser_start;
  assign to_enable = (state == SHIFT) && !ser_valid && !ser_start;

  link_timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (to_clear),
    .enable  (to_enable),
    .expired (timed_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      word_q       <= '0;
      bit_cnt      <= '0;
      word_valid_q <= 1'b0;
      busy         <= 1'b0;
      frame_error  <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      frame_error <= 1'b0;
      overrun     <= 1'b0;
      unique case (state)
        IDLE: begin
          if (ser_start) begin
            state   <= SHIFT;
            busy    <= 1'b1;
            word_q  <= start_word;
            bit_cnt <= start_cnt;
          end
        end
        SHIFT: begin
          if (ser_start) begin
            frame_error <= 1'b1;
            word_q      <= start_word;
            bit_cnt     <= start_cnt;
          end else if (ser_valid) begin
            word_q[bit_idx] <= ser_bit;
            bit_cnt         <= bit_cnt + 1'b1;
            if (last_bit) begin
              state        <= HOLD;
              busy         <= 1'b0;
              word_valid_q <= 1'b1;
            end
          end else if (timed_out) begin
            frame_error <= 1'b1;
            state       <= IDLE;
            busy        <= 1'b0;
            word_q      <= '0;
            bit_cnt     <= '0;
          end
        end
        HOLD: begin
          if (word.word_ready) begin
            word_valid_q <= 1'b0;
            // A start coinciding with the accept begins the next frame at once.
            if (ser_start) begin
              state   <= SHIFT;
              busy    <= 1'b1;
              word_q  <= start_word;
              bit_cnt <= start_cnt;
            end else begin
              state   <= IDLE;
              bit_cnt <= '0;
            end
          end else if (ser_start) begin
            overrun <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign word.word_data  = word_q;
  assign word.word_valid = word_valid_q;
  assign state_dbg       = state;

endmodule

// File: tb/tb_serial_word_receiver.sv
// Randomized bench for serial_word_receiver: words are serialized LSB-first
// by the bench and the expected result is simply the word that was sent.
module tb_serial_word_receiver;
  import link_pkg::*;

  localparam int W  = 28;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        ser_start;
  logic        ser_valid;
  logic        ser_bit;
  logic        busy;
  logic        frame_error;
  logic        overrun;
  link_state_t state_dbg;

  serial_word_receiver_if #(.BIT_WIDTH(W)) wif ();

  serial_word_receiver #(
    .BIT_WIDTH      (W),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ser_start   (ser_start),
    .ser_valid   (ser_valid),
    .ser_bit     (ser_bit),
    .word        (wif),
    .busy        (busy),
    .frame_error (frame_error),
    .overrun     (overrun),
    .state_dbg   (state_dbg)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    rst           = 1'b1;
    ser_start     = 1'b0;
    ser_valid     = 1'b0;
    ser_bit       = 1'b0;
    wif.word_ready = 1'b0;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];

  // driver tasks: inputs change 1 time unit after the edge, outputs are
  // sampled at the same point, i.e. they reflect the edge just taken
  task automatic step(input logic s, input logic v, input logic b, input logic r);
    ser_start      = s;
    ser_valid      = v;
    ser_bit        = b;
    wif.word_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [W-1:0] w, input int from, input int gmax);
    for (int i = from; i < W; i++) begin
      repeat ($urandom_range(0, gmax)) step(1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, w[i], 1'b0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if (wif.word_valid !== 1'b0 || wif.word_data !== '0 || busy !== 1'b0 ||
        frame_error !== 1'b0 || overrun !== 1'b0 || state_dbg !== IDLE) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b data=%h busy=%b ferr=%b ovr=%b st=%0d, required all 0 / IDLE",
               wif.word_valid, wif.word_data, busy, frame_error, overrun, state_dbg);
    end
  endtask

  task automatic test_single_bit();
    logic [W-1:0] w;
    w = W'(1);
    exp_q.push_back(w);
    step(1'b1, 1'b1, w[0], 1'b0);
    for (int i = 1; i < W; i++) begin
      if (i == W - 1) begin
        n_tests++;
        if (wif.word_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL early_valid: valid=%b before last strobe, required 0", wif.word_valid);
        end
      end
      step(1'b0, 1'b1, w[i], 1'b0);
    end
    n_tests++;
    if (wif.word_valid !== 1'b1 || wif.word_data !== exp_q[0]) begin
      n_fail++;
      $display("FAIL single_bit_word: valid=%b data=%h, required 1 / %h", wif.word_valid, wif.word_data, exp_q[0]);
    end
    void'(exp_q.pop_front());
    step(1'b0, 1'b0, 1'b0, 1'b1);
    n_tests++;
    if (wif.word_valid !== 1'b0 || state_dbg !== IDLE) begin
      n_fail++;
      $display("FAIL single_bit_accept: valid=%b st=%0d, required 0 / IDLE", wif.word_valid, state_dbg);
    end
  endtask

  task automatic test_stream_hold();
    logic [W-1:0] w;
    int bad;
    for (int k = 0; k < 4; k++) begin
      w = (k == 0) ? W'(28'hA5A5A5A) : W'($urandom());
      exp_q.push_back(w);
      step(1'b1, 1'b1, w[0], 1'b0);
      send_bits(w, 1, 3);
      bad = 0;
      for (int c = 0; c < 5; c++) begin
        if (wif.word_valid !== 1'b1 || wif.word_data !== exp_q[0]) bad++;
        step(1'b0, 1'b0, 1'b0, 1'b0);
      end
      n_tests++;
      if (bad != 0) begin
        n_fail++;
        $display("FAIL hold_stable[%0d]: %0d unstable cycles, last data=%h, required %h", k, bad, wif.word_data, exp_q[0]);
      end
      n_tests++;
      if (wif.word_valid !== 1'b1 || wif.word_data !== exp_q[0]) begin
        n_fail++;
        $display("FAIL stream_word[%0d]: valid=%b data=%h, required 1 / %h", k, wif.word_valid, wif.word_data, exp_q[0]);
      end
      void'(exp_q.pop_front());
      step(1'b0, 1'b0, 1'b0, 1'b1);
      n_tests++;
      if (wif.word_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL stream_accept_once[%0d]: valid=%b, required 0", k, wif.word_valid);
      end
    end
  endtask

  task automatic test_timeout();
    logic [W-1:0] w;
    int errs;
    w = W'($urandom());
    // a gap of TO-1 idle cycles is still legal
    step(1'b1, 1'b1, w[0], 1'b0);
    errs = 0;
    for (int c = 0; c < TO - 1; c++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      if (frame_error !== 1'b0) errs++;
    end
    send_bits(w, 1, 0);
    n_tests++;
    if (errs != 0 || wif.word_valid !== 1'b1 || wif.word_data !== w) begin
      n_fail++;
      $display("FAIL gap_below_timeout: errs=%0d valid=%b data=%h, required 0 / 1 / %h", errs, wif.word_valid, wif.word_data, w);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    // ten bits, then silence
    step(1'b1, 1'b1, w[0], 1'b0);
    for (int i = 1; i < 10; i++) step(1'b0, 1'b1, w[i], 1'b0);
    for (int c = 1; c <= TO; c++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      n_tests++;
      if (frame_error !== (c == TO)) begin
        n_fail++;
        $display("FAIL timeout_pulse[%0d]: frame_error=%b, required %b", c, frame_error, (c == TO));
      end
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (frame_error !== 1'b0 || state_dbg !== IDLE || wif.word_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_after: ferr=%b st=%0d valid=%b busy=%b, required 0 / IDLE / 0 / 0",
               frame_error, state_dbg, wif.word_valid, busy);
    end
  endtask

  task automatic test_restart();
    logic [W-1:0] w_old;
    logic [W-1:0] w;
    w_old = W'($urandom());
    w     = W'($urandom()) | W'(1);
    step(1'b1, 1'b1, w_old[0], 1'b0);
    for (int i = 1; i < 12; i++) step(1'b0, 1'b1, w_old[i], 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    n_tests++;
    if (frame_error !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_pulse: ferr=%b busy=%b, required 1 / 1", frame_error, busy);
    end
    exp_q.push_back(w);
    send_bits(w, 1, 2);
    n_tests++;
    if (wif.word_valid !== 1'b1 || wif.word_data !== exp_q[0]) begin
      n_fail++;
      $display("FAIL restart_word: valid=%b data=%h, required 1 / %h", wif.word_valid, wif.word_data, exp_q[0]);
    end
    void'(exp_q.pop_front());
    step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_overrun();
    logic [W-1:0] w;
    logic [W-1:0] w2;
    w  = W'($urandom());
    w2 = W'($urandom());
    exp_q.push_back(w);
    step(1'b1, 1'b1, w[0], 1'b0);
    send_bits(w, 1, 1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (overrun !== 1'b1 || wif.word_valid !== 1'b1 || wif.word_data !== exp_q[0]) begin
      n_fail++;
      $display("FAIL overrun_pulse: ovr=%b valid=%b data=%h, required 1 / 1 / %h", overrun, wif.word_valid, wif.word_data, exp_q[0]);
    end
    step(1'b0, 1'b1, ~w[0], 1'b0);
    n_tests++;
    if (overrun !== 1'b0 || wif.word_data !== exp_q[0] || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_ignores_bits: ovr=%b data=%h busy=%b, required 0 / %h / 0", overrun, wif.word_data, busy, exp_q[0]);
    end
    void'(exp_q.pop_front());
    exp_q.push_back(w2);
    step(1'b1, 1'b1, w2[0], 1'b1);
    n_tests++;
    if (overrun !== 1'b0 || busy !== 1'b1 || wif.word_valid !== 1'b0 || state_dbg !== SHIFT) begin
      n_fail++;
      $display("FAIL accept_with_start: ovr=%b busy=%b valid=%b st=%0d, required 0 / 1 / 0 / SHIFT",
               overrun, busy, wif.word_valid, state_dbg);
    end
    send_bits(w2, 1, 1);
    n_tests++;
    if (wif.word_valid !== 1'b1 || wif.word_data !== exp_q[0]) begin
      n_fail++;
      $display("FAIL no_bubble_word: valid=%b data=%h, required 1 / %h", wif.word_valid, wif.word_data, exp_q[0]);
    end
    void'(exp_q.pop_front());
    step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] w;
    int bad;
    bad = 0;
    w = W'($urandom());
    exp_q.push_back(w);
    step(1'b1, 1'b1, w[0], 1'b0);
    send_bits(w, 1, 0);
    for (int k = 0; k < 4; k++) begin
      repeat ($urandom_range(0, 3)) step(1'b0, 1'b0, 1'b0, 1'b0);
      if (wif.word_valid !== 1'b1 || wif.word_data !== exp_q[0]) bad++;
      void'(exp_q.pop_front());
      w = W'($urandom());
      exp_q.push_back(w);
      step(1'b1, 1'b1, w[0], 1'b1);
      send_bits(w, 1, 1);
    end
    n_tests++;
    if (bad != 0 || wif.word_valid !== 1'b1 || wif.word_data !== exp_q[0]) begin
      n_fail++;
      $display("FAIL back_to_back: %0d bad words, last data=%h, required %h", bad, wif.word_data, exp_q[0]);
    end
    void'(exp_q.pop_front());
    step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] w;
    w = W'($urandom());
    step(1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 1; i < 5; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
    rst = 1'b1;
    step(1'b0, 1'b1, 1'b1, 1'b0);
    rst = 1'b0;
    n_tests++;
    if (busy !== 1'b0 || wif.word_data !== '0 || wif.word_valid !== 1'b0 || state_dbg !== IDLE) begin
      n_fail++;
      $display("FAIL reset_in_shift: busy=%b data=%h valid=%b st=%0d, required 0 / 0 / 0 / IDLE",
               busy, wif.word_data, wif.word_valid, state_dbg);
    end
    step(1'b1, 1'b1, w[0], 1'b0);
    send_bits(w, 1, 0);
    rst = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    n_tests++;
    if (wif.word_valid !== 1'b0 || wif.word_data !== '0 || overrun !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_in_hold: valid=%b data=%h ovr=%b busy=%b, required all 0",
               wif.word_valid, wif.word_data, overrun, busy);
    end
    for (int c = 0; c < 3; c++) step(1'b0, 1'b1, 1'b1, 1'b0);
    n_tests++;
    if (busy !== 1'b0 || state_dbg !== IDLE || wif.word_data !== '0) begin
      n_fail++;
      $display("FAIL stray_valid: busy=%b st=%0d data=%h, required 0 / IDLE / 0", busy, state_dbg, wif.word_data);
    end
    w = W'($urandom());
    exp_q.push_back(w);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    send_bits(w, 0, 2);
    n_tests++;
    if (wif.word_valid !== 1'b1 || wif.word_data !== exp_q[0]) begin
      n_fail++;
      $display("FAIL start_then_bits: valid=%b data=%h, required 1 / %h", wif.word_valid, wif.word_data, exp_q[0]);
    end
    void'(exp_q.pop_front());
    step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    #2;
    test_reset();
    test_single_bit();
    test_stream_hold();
    test_timeout();
    test_restart();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
